mem_arbiter: RTL and testbench

- Shares the CPU's single memory port between two requesters: port F (instruction fetch) and port D (data load/store).
- Sits between the CPU FSM and memory/peripheral space. Drives the memory-side address, data_out, memory_read and memory_write signals.
- Completes each access on the mem_ready handshake, or returns a bus error after a timeout.
- Requesters must hold their request until acknowledged. Byte-order conversion is not done here; the CPU handles it.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch
// requester (F) and a data load/store requester (D).
// Each access runs IDLE -> ACCESS -> RESP. It completes on mem_ready, or
// returns a bus error after TIMEOUT_CYCLES wait cycles.
// Default arbitration is fixed priority, with D winning over F.
// Define MEM_ARB_RR_EN to get round-robin arbitration instead.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              memory_read,
    output logic              memory_write,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              timeout_hit;
    logic              sel_d_q;     // 1 = current access belongs to D
    logic              we_q;        // current access is a write
    logic              grant_d;     // arbitration result: 1 = D wins

    logic              f_ack_q, f_err_q, d_ack_q, d_err_q;
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q, data_out_q;
    logic [ADDR_W-1:0] address_q;
    logic              mem_rd_q, mem_wr_q, busy_q;

`ifdef MEM_ARB_RR_EN
    logic              last_d_q;    // 1 = most recent grant went to D

    // Round-robin: on a tie, grant the port that was not granted last
    always_comb begin
        grant_d = d_req;
        if (d_req && f_req) begin
            grant_d = ~last_d_q;
        end
    end

    // Remember the winner of every grant; the reset value D lets F win the first tie
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_d_q <= 1'b1;
        end else if (state_q == ST_IDLE && (f_req || d_req)) begin
            last_d_q <= grant_d;
        end
    end
`else
    // Fixed priority: D always beats F
    always_comb begin
        grant_d = d_req;
    end
`endif

    // Wait-cycle counter next value and timeout detection
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_d == TO_VAL);
    end

    // Access sequencer; every output is a register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_d_q    <= 1'b0;
            we_q       <= 1'b0;
            f_ack_q    <= 1'b0;
            f_err_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
            data_out_q <= '0;
            address_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Acks and errors are single-cycle pulses unless set below
            f_ack_q <= 1'b0;
            f_err_q <= 1'b0;
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        sel_d_q <= grant_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_ACCESS;
                        if (grant_d) begin
                            address_q <= d_addr;
                            we_q      <= d_we;
                            mem_rd_q  <= ~d_we;
                            mem_wr_q  <= d_we;
                            if (d_we) begin
                                data_out_q <= d_wdata;
                            end
                        end else begin
                            address_q <= f_addr;
                            we_q      <= 1'b0;
                            mem_rd_q  <= 1'b1;
                            mem_wr_q  <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt_q <= cnt_d;
                    if (mem_ready) begin
                        // Normal completion; also wins in the final counted cycle
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= ST_RESP;
                        if (sel_d_q) begin
                            d_ack_q <= 1'b1;
                            if (!we_q) begin
                                d_rdata_q <= data_in;
                            end
                        end else begin
                            f_ack_q   <= 1'b1;
                            f_rdata_q <= data_in;
                        end
                    end else if (timeout_hit) begin
                        // Abort: a timed-out read returns zero data
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state_q  <= ST_RESP;
                        if (sel_d_q) begin
                            d_ack_q <= 1'b1;
                            d_err_q <= 1'b1;
                            if (!we_q) begin
                                d_rdata_q <= '0;
                            end
                        end else begin
                            f_ack_q   <= 1'b1;
                            f_err_q   <= 1'b1;
                            f_rdata_q <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    // Requests are not sampled here; the requester updates them now
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign f_ack        = f_ack_q;
    assign f_err        = f_err_q;
    assign f_rdata      = f_rdata_q;
    assign d_ack        = d_ack_q;
    assign d_err        = d_err_q;
    assign d_rdata      = d_rdata_q;
    assign address      = address_q;
    assign data_out     = data_out_q;
    assign memory_read  = mem_rd_q;
    assign memory_write = mem_wr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter.
// The bench acts as memory and decides each access's wait count itself.
// Expectations come from a transaction-level model of the rules: who wins,
// how many strobe cycles, whether the access errors, and the rdata values.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          f_req, f_ack, f_err;
    logic [AW-1:0] f_addr;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we, d_ack, d_err;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out, data_in;
    logic          memory_read, memory_write, mem_ready, busy;

    int            n_checks = 0;
    int            n_err    = 0;

    // Model state
    logic [DW-1:0] m_f_rdata, m_d_rdata;
    bit            m_last_d;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_reset(n_reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .address(address), .data_out(data_out), .data_in(data_in),
        .memory_read(memory_read), .memory_write(memory_write),
        .mem_ready(mem_ready), .busy(busy)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Which port should be granted given the pending requests
    function automatic bit pick_d(input bit fr, input bit dr);
        if (!dr) return 1'b0;
        if (!fr) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return ~m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check1({tag, ".f_ack0"}, f_ack, 1'b0);
        check1({tag, ".d_ack0"}, d_ack, 1'b0);
        check1({tag, ".busy0"}, busy, 1'b0);
        check1({tag, ".rd0"}, memory_read, 1'b0);
        check1({tag, ".wr0"}, memory_write, 1'b0);
    endtask

    // Serve one access, starting in an IDLE cycle with the requests already driven.
    // waits = number of mem_ready=0 cycles before mem_ready=1.
    task automatic serve(input bit exp_d, input int waits, input logic [DW-1:0] rd_word,
                         input bit hold, input string tag);
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] wd;
        bit            to;
        int            n;
        a  = exp_d ? d_addr : f_addr;
        we = exp_d ? d_we : 1'b0;
        wd = d_wdata;
        to = (TO > 0) && (waits + 1 > TO);
        n  = to ? TO : waits + 1;
        m_last_d = exp_d;
        step;
        for (int i = 0; i < n; i++) begin
            checkw({tag, ".addr"}, address, a);
            check1({tag, ".rd"}, memory_read, ~we);
            check1({tag, ".wr"}, memory_write, we);
            if (we) checkw({tag, ".dout"}, data_out, wd);
            check1({tag, ".busy"}, busy, 1'b1);
            check1({tag, ".f_ack_wait"}, f_ack, 1'b0);
            check1({tag, ".d_ack_wait"}, d_ack, 1'b0);
            mem_ready = (i == waits);
            data_in   = (i == waits) ? rd_word : $urandom;
            step;
        end
        mem_ready = 1'b0;
        data_in   = $urandom;
        if (!we) begin
            if (exp_d) m_d_rdata = to ? '0 : rd_word;
            else       m_f_rdata = to ? '0 : rd_word;
        end
        check1({tag, ".f_ack"}, f_ack, ~exp_d);
        check1({tag, ".d_ack"}, d_ack, exp_d);
        check1({tag, ".f_err"}, f_err, ~exp_d & to);
        check1({tag, ".d_err"}, d_err, exp_d & to);
        check1({tag, ".rd_off"}, memory_read, 1'b0);
        check1({tag, ".wr_off"}, memory_write, 1'b0);
        check1({tag, ".busy_resp"}, busy, 1'b1);
        checkw({tag, ".f_rdata"}, f_rdata, m_f_rdata);
        checkw({tag, ".d_rdata"}, d_rdata, m_d_rdata);
        if (!hold) begin
            if (exp_d) d_req = 1'b0;
            else       f_req = 1'b0;
        end
        step;
        check_quiet({tag, ".idle"});
    endtask

    initial begin
        bit fr, dr, first;
        n_reset   = 1'b0;
        f_req     = 1'b0; f_addr = '0;
        d_req     = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        data_in   = '0;   mem_ready = 1'b0;
        m_f_rdata = '0;   m_d_rdata = '0; m_last_d = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        checkw("reset.addr", address, '0);
        checkw("reset.dout", data_out, '0);
        checkw("reset.f_rdata", f_rdata, '0);
        checkw("reset.d_rdata", d_rdata, '0);
        check1("reset.f_err", f_err, 1'b0);
        check1("reset.d_err", d_err, 1'b0);
        n_reset = 1'b1;
        step;

        // Fetch read, zero wait
        f_req = 1'b1; f_addr = 32'h10;
        serve(1'b0, 0, 32'hE3A01005, 1'b0, "fetch");

        // Data write with 3 wait states
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        serve(1'b1, 3, 32'h5A5A5A5A, 1'b0, "write");
        d_we = 1'b0;

        // Simultaneous requests, twice
        for (int r = 0; r < 2; r++) begin
            f_req = 1'b1; f_addr = 32'h20;
            d_req = 1'b1; d_addr = 32'h200;
            first = pick_d(1'b1, 1'b1);
            serve(first, 0, $urandom, 1'b0, "tie1");
            serve(~first, 0, $urandom, 1'b0, "tie2");
        end

        // Timeout on a D read, then a normal fetch
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        serve(1'b1, 10, 32'h11112222, 1'b0, "timeout");
        f_req = 1'b1; f_addr = 32'h44;
        serve(1'b0, 0, 32'hCAFEF00D, 1'b0, "after_to");

        // mem_ready in the final counted cycle completes normally
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
        serve(1'b1, TO - 1, 32'h0BADF00D, 1'b0, "last_cycle");

        // Reset in the middle of an access
        f_req = 1'b1; f_addr = 32'h40;
        step;
        check1("rst.rd_on", memory_read, 1'b1);
        step;
        n_reset = 1'b0;
        #1;
        check_quiet("rst.async");
        checkw("rst.addr", address, '0);
        m_f_rdata = '0; m_d_rdata = '0; m_last_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            check_quiet("rst.hold");
        end
        n_reset = 1'b1;
        serve(1'b0, 0, 32'h600D600D, 1'b0, "rst.restart");

        // Back-to-back fetches with req held
        f_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            f_addr = 32'(4 * k);
            serve(1'b0, 0, $urandom, (k < 2), "b2b");
        end

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!fr && !dr) fr = 1'b1;
            f_req   = fr;  f_addr = $urandom;
            d_req   = dr;  d_addr = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            d_wdata = $urandom;
            first   = pick_d(fr, dr);
            serve(first, $urandom_range(0, 5), $urandom, 1'b0, "rnd1");
            if (fr && dr) serve(~first, $urandom_range(0, 5), $urandom, 1'b0, "rnd2");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
